mem_access_ctrl: RTL

- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
- Observes the load/store controls held in the EX/MEM pipeline register and runs a req/ack handshake with a multi-cycle data memory.
- Drives the pipeline hold signal (EX/MEM, ID/EX, IF/ID, PC hold-enables) until the access completes, then presents load data to MEM/WB.
- Also keeps stall and access counters, and a sticky timeout error.

---
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack handshake with a multi-cycle
// memory, pipeline hold generation, stall/access counters and a sticky timeout error.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        clk_i,
   input  logic        start_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] access_cnt_o
);

   localparam int unsigned DW = 32;
   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [DW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [DW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DW-1:0]   access_cnt_q, access_cnt_d;
   logic            acc;
   logic            done_evt;

   assign acc = MemRead_i | MemWrite_i;

   // Next-state, handshake and datapath capture
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      valid_d  = valid_q;
      err_d    = err_q;
      to_d     = to_q;
      stall_o  = 1'b0;
      done_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               stall_o = 1'b1;
               state_d = BUSY;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               we_d    = MemWrite_i;
               req_d   = 1'b1;
               to_d    = '0;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               req_d    = 1'b0;
               if (!we_q) begin
                  rdata_d = mem_rdata_i;
                  valid_d = 1'b1;
               end
               state_d  = DONE;
               done_evt = 1'b1;
            end else if (TO_EN && (to_q == TO_LAST)) begin
               req_d    = 1'b0;
               err_d    = 1'b1;
               rdata_d  = '0;
               valid_d  = !we_q;
               state_d  = DONE;
               done_evt = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         DONE: begin
            // Inputs still hold the completed instruction here, so acc is ignored
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating counters
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      access_cnt_d = access_cnt_q;
      if (stall_o && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + DW'(1);
      if (done_evt && (access_cnt_q != '1))
         access_cnt_d = access_cnt_q + DW'(1);
   end

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         to_q         <= '0;
         stall_cnt_q  <= '0;
         access_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         to_q         <= to_d;
         stall_cnt_q  <= stall_cnt_d;
         access_cnt_q <= access_cnt_d;
      end
   end

   assign mem_req_o     = req_q;
   assign mem_we_o      = we_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = valid_q;
   assign err_o         = err_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign access_cnt_o  = access_cnt_q;

endmodule
